// File: rtl/icache_line_fill_if.sv
// Bus bundle for the icache line-fill engine: the mm_* request/response
// handshake toward the cache and the 32-bit instruction SRAM port.
// slave  = the fill engine, master = its environment (cache + SRAM).
interface icache_line_fill_if #(
  parameter int SRAM_AW = 14
);
  logic               i_mm_rden;
  logic [31:0]        i_mm_addr;
  logic               o_mm_gnt;
  logic [127:0]       o_mm_rdata;
  logic               o_mm_rvalid;
  logic               o_sram_rden;
  logic [SRAM_AW-1:0] o_sram_addr;
  logic [31:0]        i_sram_rdata;
  logic               i_sram_busy;
  logic               o_fill_err;

  modport slave (
    input  i_mm_rden, i_mm_addr, i_sram_rdata, i_sram_busy,
    output o_mm_gnt, o_mm_rdata, o_mm_rvalid, o_sram_rden, o_sram_addr, o_fill_err
  );

  modport master (
    output i_mm_rden, i_mm_addr, i_sram_rdata, i_sram_busy,
    input  o_mm_gnt, o_mm_rdata, o_mm_rvalid, o_sram_rden, o_sram_addr, o_fill_err
  );
endinterface

// File: rtl/icache_line_fill.sv
// icache_line_fill: fetches one 128-bit line as 4 sequential 32-bit SRAM
// beats, assembles it and returns it with a single-cycle rvalid pulse.
// Beat issue stalls while the data port owns the SRAM (i_sram_busy).
// Optional feature macro: ICACHE_FILL_RANGE_CHK_EN -- out-of-range line
// requests answer immediately with a line of NOPs and o_fill_err.
module icache_line_fill #(
  parameter int          SRAM_AW     = 14,
  parameter int          SRAM_RD_LAT = 1,
  parameter logic [31:0] IMEM_BASE   = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  icache_line_fill_if.slave bus
);
  localparam int          LAW = SRAM_AW - 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t                 state_q, state_d;
  logic [LAW-1:0]         line_addr_q, line_addr_d;
  logic [1:0]             issue_cnt_q, issue_cnt_d;
  logic [1:0]             ret_cnt_q, ret_cnt_d;
  logic [SRAM_RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [3:0][31:0]       line_q, line_d;
  logic [127:0]           rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   err_q, err_d;
  logic                   gnt, strobe, ret_vld, out_of_range;

  // Grant is combinational and only offered from IDLE; masked during reset
  // so every output reads 0 while i_rst is high.
  assign gnt     = (state_q == IDLE) && bus.i_mm_rden && !i_rst;
  assign strobe  = (state_q == ISSUE) && !bus.i_sram_busy;
  assign ret_vld = vld_pipe_q[SRAM_RD_LAT-1];

`ifdef ICACHE_FILL_RANGE_CHK_EN
  assign out_of_range = bus.i_mm_addr[31:SRAM_AW+2] != IMEM_BASE[31:SRAM_AW+2];
  logic unused_addr;
  assign unused_addr = ^bus.i_mm_addr[3:0];
`else
  // Upper address bits alias into the SRAM; nothing is ever out of range.
  assign out_of_range = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{bus.i_mm_addr[31:SRAM_AW+2], bus.i_mm_addr[3:0], IMEM_BASE};
`endif

  // Next-state: FSM, beat issue, return tracking and line assembly.
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    line_d      = line_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;

    // Each strobe is tagged and its data lands SRAM_RD_LAT cycles later,
    // independent of busy.
    vld_pipe_d[0] = strobe;
    for (int k = 1; k < SRAM_RD_LAT; k++) vld_pipe_d[k] = vld_pipe_q[k-1];

    if (ret_vld) begin
      line_d[ret_cnt_q] = bus.i_sram_rdata;
      ret_cnt_d         = ret_cnt_q + 2'd1;
    end

    case (state_q)
      IDLE: if (gnt) begin
        line_addr_d = bus.i_mm_addr[SRAM_AW+1:4];
        issue_cnt_d = 2'd0;
        ret_cnt_d   = 2'd0;
        if (out_of_range) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = {4{NOP}};
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: if (strobe) begin
        issue_cnt_d = issue_cnt_q + 2'd1;
        if (issue_cnt_q == 2'd3) state_d = DRAIN;
      end
      // Last beat is merged straight into the output so rvalid follows it
      // by one cycle; o_mm_rdata keeps the previous line until then.
      DRAIN: if (ret_vld && ret_cnt_q == 2'd3) begin
        state_d  = RESP;
        rvalid_d = 1'b1;
        rdata_d  = {bus.i_sram_rdata, line_q[2], line_q[1], line_q[0]};
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; async reset also drops any SRAM data still in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      vld_pipe_q  <= '0;
      line_q      <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      line_q      <= line_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_mm_gnt    = gnt;
  assign bus.o_sram_rden = strobe;
  // Beat index sits below line_addr, so it can never carry into it.
  assign bus.o_sram_addr = {line_addr_q, issue_cnt_q};
  assign bus.o_mm_rdata  = rdata_q;
  assign bus.o_mm_rvalid = rvalid_q;
  assign bus.o_fill_err  = err_q;
endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: two instances (read latency 1 and 3), each
// with a behavioural SRAM. Expected strobe cycles/addresses, rvalid cycle
// and line contents come from a reference model: strobes fall on the first
// four non-busy cycles after the grant, rvalid LAT+1 cycles after the last.
module tb_icache_line_fill;
  localparam int AW = 14;
`ifdef ICACHE_FILL_RANGE_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          rden[2];
  logic [31:0]   addr[2];
  logic          busy[2];
  logic          gnt[2], rvalid[2], srden[2], ferr[2];
  logic [127:0]  rdata[2];
  logic [AW-1:0] saddr[2];
  logic [31:0]   srdata[2];

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  pat = 32'hA000_0000;
  logic [31:0]  mul = 32'd1;
  logic [127:0] prev_line[2];

  icache_line_fill_if #(.SRAM_AW(AW)) bus0 ();
  icache_line_fill_if #(.SRAM_AW(AW)) bus1 ();

  assign bus0.i_mm_rden = rden[0];  assign bus1.i_mm_rden = rden[1];
  assign bus0.i_mm_addr = addr[0];  assign bus1.i_mm_addr = addr[1];
  assign bus0.i_sram_busy = busy[0]; assign bus1.i_sram_busy = busy[1];
  assign bus0.i_sram_rdata = srdata[0]; assign bus1.i_sram_rdata = srdata[1];
  assign gnt[0] = bus0.o_mm_gnt;       assign gnt[1] = bus1.o_mm_gnt;
  assign rvalid[0] = bus0.o_mm_rvalid; assign rvalid[1] = bus1.o_mm_rvalid;
  assign rdata[0] = bus0.o_mm_rdata;   assign rdata[1] = bus1.o_mm_rdata;
  assign srden[0] = bus0.o_sram_rden;  assign srden[1] = bus1.o_sram_rden;
  assign saddr[0] = bus0.o_sram_addr;  assign saddr[1] = bus1.o_sram_addr;
  assign ferr[0] = bus0.o_fill_err;    assign ferr[1] = bus1.o_fill_err;

  icache_line_fill #(.SRAM_AW(AW), .SRAM_RD_LAT(1), .IMEM_BASE(32'h0)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0));
  icache_line_fill #(.SRAM_AW(AW), .SRAM_RD_LAT(3), .IMEM_BASE(32'h0)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1));

  // SRAM content: word i = pat + mul*i
  function automatic logic [31:0] word(input logic [AW-1:0] i);
    return pat + mul * {18'b0, i};
  endfunction

  logic [31:0] s0_q;
  logic [31:0] s1_q[3];
  always @(posedge clk) s0_q <= srden[0] ? word(saddr[0]) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    s1_q[0] <= srden[1] ? word(saddr[1]) : 32'hDEAD_BEEF;
    s1_q[1] <= s1_q[0];
    s1_q[2] <= s1_q[1];
  end
  assign srdata[0] = s0_q;
  assign srdata[1] = s1_q[2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input int d, input string tag);
    chk({tag, "_gnt"}, gnt[d], 0);
    chk({tag, "_srden"}, srden[d], 0);
    chk({tag, "_rvalid"}, rvalid[d], 0);
    chk({tag, "_ferr"}, ferr[d], 0);
  endtask

  // One request on instance d. bmask bit c = busy in cycle T+c.
  task automatic fill(input int d, input logic [31:0] a, input logic [63:0] bmask,
                      input bit keep, input logic [31:0] nxt, input bit rnd);
    int sc[4];
    int n, ev, lat, k;
    bit rng;
    logic [AW-1:0] base;
    logic [127:0] exp_line;
    lat  = (d == 0) ? 1 : 3;
    rng  = ERR_EN && (a[31:AW+2] != '0);
    base = {a[AW+1:4], 2'b00};
    n = 0;
    for (int c = 1; n < 4 && c < 64; c++) if (!bmask[c]) begin sc[n] = c; n++; end
    ev = rng ? 1 : sc[3] + lat + 1;
    exp_line = rng ? {4{32'h0000_0013}}
                   : {word(base + 3), word(base + 2), word(base + 1), word(base)};
    @(posedge clk); #1;
    rden[d] = 1'b1; addr[d] = a; busy[d] = bmask[0];
    @(negedge clk);
    chk("gnt", gnt[d], 1);
    k = 0;
    for (int c = 1; c <= ev; c++) begin
      @(posedge clk); #1;
      busy[d] = (c < 64) ? bmask[c] : 1'b0;
      if (keep) begin
        rden[d] = 1'b1; addr[d] = nxt;
      end else if (rnd) begin
        rden[d] = 1'($urandom_range(0, 1)); addr[d] = $urandom;
      end else begin
        rden[d] = 1'b0;
      end
      @(negedge clk);
      chk("gnt_inflight", gnt[d], 0);
      if (!rng && k < 4 && c == sc[k]) begin
        chk("strobe", srden[d], 1);
        chk("sram_addr", saddr[d], base + k);
        k++;
      end else begin
        chk("no_strobe", srden[d], 0);
      end
      chk("rvalid", rvalid[d], c == ev);
      chk("rdata", rdata[d], (c == ev) ? exp_line : prev_line[d]);
      chk("fill_err", ferr[d], rng && c == ev);
    end
    prev_line[d] = exp_line;
    rden[d] = keep;
    busy[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rden[d] = 1'b0;
      @(negedge clk);
      chk_quiet(d, "idle");
    end
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] a;
    int d;
    for (int i = 0; i < 2; i++) begin
      rden[i] = 1'b0; addr[i] = '0; busy[i] = 1'b0; prev_line[i] = '0;
    end
    // reset state, with a pending request that must not be granted
    rst = 1'b1;
    rden[0] = 1'b1;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk_quiet(i, "reset");
      chk("reset_rdata", rdata[i], 0);
      chk("reset_saddr", saddr[i], 0);
    end
    #9;
    rst = 1'b0;
    rden[0] = 1'b0;

    // basic fill and busy stall, latency 1
    fill(0, 32'h0000_0024, 64'd0, 0, 0, 0);
    idle(0, 1);
    fill(0, 32'h0000_0024, (64'd1 << 2) | (64'd1 << 3), 0, 0, 0);
    idle(0, 1);

    // reset in the middle of ISSUE after two strobes
    @(posedge clk); #1; rden[0] = 1'b1; addr[0] = 32'h0000_0024;
    @(negedge clk); chk("rst_gnt", gnt[0], 1);
    @(posedge clk); #1; rden[0] = 1'b0;
    @(negedge clk); chk("rst_strobe0", srden[0], 1);
    @(posedge clk); #1;
    @(negedge clk); chk("rst_strobe1", srden[0], 1);
    @(posedge clk); #1; rst = 1'b1; rden[0] = 1'b1;
    #1;
    chk_quiet(0, "rst_mid");
    chk("rst_mid_rdata", rdata[0], 0);
    #1; rst = 1'b0; rden[0] = 1'b0;
    prev_line[0] = '0; prev_line[1] = '0;
    @(negedge clk); chk_quiet(0, "post_rst");
    idle(0, 3);
    pat = $urandom; mul = $urandom | 32'd1;
    fill(0, 32'h0000_0024, 64'd0, 0, 0, 0);

    // back-to-back with rden held high
    fill(0, 32'h0000_0000, 64'd0, 1, 32'h0000_0010, 0);
    fill(0, 32'h0000_0010, 64'd0, 0, 0, 0);
    idle(0, 1);

    // latency 3, top line of memory; then a long busy stall
    fill(1, 32'h0000_FFF0, 64'd0, 0, 0, 0);
    idle(1, 1);
    fill(1, 32'h0000_1230, 64'h0000_01FF_FFFF_FFFE, 0, 0, 0);
    idle(1, 1);

    // upper address bits: range error or aliasing depending on build
    fill(0, 32'h8000_0000, 64'd0, 0, 0, 0);
    idle(0, 1);
    fill(0, 32'h8000_0024, 64'd0, 0, 0, 0);
    idle(0, 1);

    // randomized fills with random busy, stray rden pulses and data
    for (int it = 0; it < 16; it++) begin
      d = int'($urandom_range(0, 1));
      pat = $urandom; mul = $urandom | 32'd1;
      a = $urandom;
      if (ERR_EN && $urandom_range(0, 3) != 0) a[31:AW+2] = '0;
      m = '0;
      for (int b = 1; b < 13; b++) if ($urandom_range(0, 3) == 0) m |= (64'd1 << b);
      fill(d, a, m, 0, 0, 1);
      idle(d, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
